// File: rtl/gpr_ctrl_pkg.sv
// gpr_ctrl_pkg: sequencer state encoding, opcode values and instruction field positions
package gpr_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_MVI = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 2;
  localparam int RS_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/gpr_ctrl_decode.sv
// gpr_ctrl_decode: combinational opcode classifier and ALU opcode map
module gpr_ctrl_decode
  import gpr_ctrl_pkg::*;
(
  input  logic [3:0] i_op,
  output logic       o_is_alu,
  output logic       o_is_imm,
  output logic       o_is_branch,
  output logic       o_is_cond,
  output logic       o_is_halt,
  output logic       o_is_illegal,
  output logic [3:0] o_alu_op
);
  always_comb begin
    o_is_alu     = i_op == OP_MOV || (i_op >= OP_ADD && i_op <= OP_NOT);
    o_is_imm     = i_op == OP_MVI;
    o_is_branch  = i_op == OP_JMP || i_op == OP_JZ;
    o_is_cond    = i_op == OP_JZ;
    o_is_halt    = i_op == OP_HLT;
    o_is_illegal = i_op > OP_JZ && i_op < OP_HLT;
    o_alu_op     = o_is_alu ? i_op : 4'h0;
  end
endmodule

// File: rtl/gpr_ctrl.sv
// gpr_ctrl: multi-cycle fetch/decode/exec/write-back sequencer for the 8-bit GPR datapath
// GPR_CTRL_ILLEGAL_TRAP_EN: opcodes B-E halt and set sticky illegal_op
module gpr_ctrl
  import gpr_ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [2:0]      rd_sel,
  output logic [2:0]      rs_sel,
  output logic            gpr_load,
  output logic [3:0]      alu_op,
  output logic            wb_sel,
  output logic [7:0]      imm,
  input  logic            alu_zero,
  input  logic            resume,
  output logic            halted,
`ifdef GPR_CTRL_ILLEGAL_TRAP_EN
  output logic            illegal_op,
`endif
  output logic [PC_W-1:0] pc
);
`ifdef GPR_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            r_z, r_req;
  logic            w_alu, w_imm, w_branch, w_cond, w_halt, w_illegal, w_halt_go;
  logic [3:0]      w_alu_op;

  gpr_ctrl_decode u_dec (
    .i_op        (r_ir[OP_HI:OP_LO]),
    .o_is_alu    (w_alu),
    .o_is_imm    (w_imm),
    .o_is_branch (w_branch),
    .o_is_cond   (w_cond),
    .o_is_halt   (w_halt),
    .o_is_illegal(w_illegal),
    .o_alu_op    (w_alu_op)
  );

  assign w_halt_go = w_halt | (TRAP_EN & w_illegal);

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = imem_ack ? DECODE : FETCH;
      DECODE:  w_next = w_halt_go ? HALT : (w_alu | w_imm | w_branch) ? EXEC : FETCH;
      EXEC:    w_next = w_branch ? FETCH : WB;
      WB:      w_next = FETCH;
      HALT:    w_next = resume ? FETCH : HALT;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= w_next == FETCH;
      if (r_state == FETCH && imem_ack) begin
        r_ir <= imem_data;
        r_pc <= r_pc + 1'b1;
      end
      if (r_state == EXEC && w_branch && (!w_cond || r_z))
        r_pc <= PC_W'(r_ir[IMM_HI:IMM_LO]);
      if (r_state == WB && w_alu)
        r_z <= alu_zero;
    end
  end

`ifdef GPR_CTRL_ILLEGAL_TRAP_EN
  logic r_ill;
  always_ff @(posedge clk) begin
    if (rst) r_ill <= 1'b0;
    else if (r_state == DECODE && w_illegal) r_ill <= 1'b1;
  end
  assign illegal_op = r_ill;
`endif

  // Reset must also cancel the write strobe of an in-flight WB cycle.
  assign gpr_load  = r_state == WB && !rst;
  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign rd_sel    = r_ir[RD_HI:RD_LO];
  assign rs_sel    = r_ir[RS_HI:RS_LO];
  assign imm       = r_ir[IMM_HI:IMM_LO];
  assign alu_op    = w_alu_op;
  assign wb_sel    = w_imm;
  assign halted    = r_state == HALT;
endmodule
